// File: rtl/aes_inv_pkg.sv
// Shared definitions for the iterative AES-128 inverse-cipher controller.
// Round count, key index width, FSM encoding and byte placement helper.
package aes_inv_pkg;

   localparam int unsigned NR        = 10;
   localparam int unsigned KEY_IDX_W = 4;

   typedef enum logic [2:0] {
      PRIME,
      IDLE,
      ROUND,
      FINAL,
      DONE
   } st_e;

   // Column-major placement: byte 0 = row0/col0, byte 1 = row1/col0.
   function automatic int bidx(input int row, input int col);
      return 4 * col + row;
   endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Block I/O channel of the AES-128 inverse-cipher controller.
// slave = controller side, master = block producer/consumer side.
interface aes_inv_round_ctrl_if;

   logic [0:127] Data_In;
   logic         In_Valid;
   logic         In_Ready;
   logic [0:127] Data_Out;
   logic         Out_Valid;
   logic         Out_Ready;

   modport slave (
      input  Data_In, In_Valid, Out_Ready,
      output In_Ready, Data_Out, Out_Valid
   );

   modport master (
      output Data_In, In_Valid, Out_Ready,
      input  In_Ready, Data_Out, Out_Valid
   );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last is set.
module aes_inv_round
   import aes_inv_pkg::*;
(
   input  logic [0:127] st,
   input  logic [0:127] rk,
   input  logic         last,
   output logic [0:127] nxt
);

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse affine map, then field inverse computed as y^254.
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      logic [7:0] r;
      logic [7:0] s;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      r = 8'h01;
      s = y;
      for (int i = 0; i < 7; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {
         gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
         gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
         gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
         gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
      };
   endfunction

   logic [0:127] sub;
   logic [0:127] ark;
   logic [0:127] mix;

   always_comb begin
      sub = '0;
      mix = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub[8*bidx(r, c) +: 8] =
               inv_sbox(st[8*bidx(r, (c + 4 - r) % 4) +: 8]);
         end
      end
      ark = sub ^ rk;
      for (int c = 0; c < 4; c++) begin
         mix[32*c +: 32] = inv_mix(ark[32*c +: 32]);
      end
      nxt = last ? ark : mix;
   end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller, one inverse round per cycle.
// Optional AES_INV_ABORT_EN adds an Abort input that drops the block.
module aes_inv_round_ctrl #(
   parameter int unsigned NR = 10
) (
   input  logic                               clk,
   input  logic                               reset,
   aes_inv_round_ctrl_if.slave                blk,
   output logic [aes_inv_pkg::KEY_IDX_W-1:0]  Key_Addr,
   input  logic [0:127]                       Key_In
`ifdef AES_INV_ABORT_EN
   ,
   input  logic                               Abort
`endif
);
   import aes_inv_pkg::*;

   localparam logic [KEY_IDX_W-1:0] LAST_KEY = KEY_IDX_W'(NR);

   st_e                  cur;
   st_e                  nxt;
   logic [KEY_IDX_W-1:0] round_q;
   logic [KEY_IDX_W-1:0] round_d;
   logic [KEY_IDX_W-1:0] addr_d;
   logic [0:127]         state_q;
   logic [0:127]         state_d;
   logic [0:127]         rnd_out;
   logic                 last;

   assign last = (cur == FINAL);

   aes_inv_round u_round (
      .st   (state_q),
      .rk   (Key_In),
      .last (last),
      .nxt  (rnd_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cur      <= PRIME;
         round_q  <= '0;
         Key_Addr <= LAST_KEY;
         state_q  <= '0;
      end else begin
         cur      <= nxt;
         round_q  <= round_d;
         Key_Addr <= addr_d;
         state_q  <= state_d;
      end
   end

   always_comb begin
      nxt     = cur;
      round_d = round_q;
      addr_d  = Key_Addr;
      state_d = state_q;
      unique case (cur)
         PRIME: nxt = IDLE;
         IDLE: begin
            if (blk.In_Valid) begin
               state_d = blk.Data_In ^ Key_In;
               round_d = LAST_KEY - 1'b1;
               addr_d  = LAST_KEY - 1'b1;
               nxt     = ROUND;
            end
         end
         ROUND: begin
            state_d = rnd_out;
            round_d = round_q - 1'b1;
            addr_d  = round_q - 1'b1;
            if (round_q == 1) nxt = FINAL;
         end
         FINAL: begin
            state_d = rnd_out;
            addr_d  = LAST_KEY;
            nxt     = DONE;
         end
         DONE: begin
            if (blk.Out_Ready) nxt = IDLE;
         end
         default: nxt = PRIME;
      endcase
`ifdef AES_INV_ABORT_EN
      if (Abort && (cur == ROUND || cur == FINAL || cur == DONE)) begin
         nxt     = IDLE;
         addr_d  = LAST_KEY;
         round_d = '0;
      end
`endif
   end

   assign blk.In_Ready  = (cur == IDLE);
   assign blk.Out_Valid = (cur == DONE);
   assign blk.Data_Out  = (cur == DONE) ? state_q : '0;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: FIPS-197 C.1 vector plus blocks
// encrypted by a forward AES model, checked through an output scoreboard.
module tb_aes_inv_round_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic abort_s = 1'b0;
   logic [3:0] key_addr;
   logic [0:127] key_in;
   logic [127:0] kmem [11];
   logic [7:0] sbox [256];

   aes_inv_round_ctrl_if bif ();

   aes_inv_round_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .blk      (bif),
      .Key_Addr (key_addr),
`ifdef AES_INV_ABORT_EN
      .Key_In   (key_in),
      .Abort    (abort_s)
`else
      .Key_In   (key_in)
`endif
   );

   always #5 clk = ~clk;

   // Key RAM address register is the controller's Key_Addr.
   assign key_in = (key_addr <= 4'd10) ? kmem[key_addr] : '0;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int acc_gap = 0;
   int acc_cnt = 0;
   logic [127:0] cur_pt;
   logic [127:0] exp_q [$];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   task automatic init_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                   {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]}
                ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         kmem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s, t;
      logic [7:0] a0, a1, a2, a3;
      s = pt ^ kmem[0];
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               t[127-8*(4*c+w) -: 8] = sbox[s[127-8*(4*((c+w)%4)+w) -: 8]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8];
               a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8];
               a3 = t[103-32*c -: 8];
               t[127-32*c -: 32] = {
                  xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
         end
         s = t ^ kmem[r];
      end
      return s;
   endfunction

   task automatic mk(output logic [127:0] pt, output logic [127:0] ct);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt);
   endtask

   // Scoreboard: push on input handshake, pop on output transfer.
   task automatic step();
      logic [127:0] e;
      @(negedge clk);
      if (!reset && bif.In_Valid && bif.In_Ready) begin
         exp_q.push_back(cur_pt);
         acc_gap = cyc - last_acc;
         last_acc = cyc;
         acc_cnt++;
      end
      if (!reset && !abort_s && bif.Out_Valid && bif.Out_Ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out: got %h, no block pending", bif.Data_Out);
         end else begin
            e = exp_q.pop_front();
            if (bif.Data_Out !== e) begin
               errors++;
               $display("FAIL data_out: got %h expected %h", bif.Data_Out, e);
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input int budget);
      bif.Out_Ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d blocks still pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks += 4;
      if (bif.In_Ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready: got %b expected 0", bif.In_Ready);
      end
      if (bif.Out_Valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid: got %b expected 0", bif.Out_Valid);
      end
      if (bif.Data_Out !== 128'h0) begin
         errors++; $display("FAIL rst_data_out: got %h expected 0", bif.Data_Out);
      end
      if (key_addr !== 4'd10) begin
         errors++; $display("FAIL rst_key_addr: got %0d expected 10", key_addr);
      end
      reset = 1'b0;
      bif.In_Valid = 1'b1;
      bif.Data_In = C1_CT;
      cur_pt = C1_PT;
      checks++;
      if (bif.In_Ready !== 1'b0) begin
         errors++; $display("FAIL prime_in_ready: got %b expected 0", bif.In_Ready);
      end
      step();
      bif.In_Valid = 1'b0;
      checks++;
      if (bif.In_Ready !== 1'b1) begin
         errors++; $display("FAIL idle_in_ready: got %b expected 1", bif.In_Ready);
      end
   endtask

   task automatic test_c1();
      bif.Out_Ready = 1'b1;
      bif.Data_In = C1_CT;
      cur_pt = C1_PT;
      bif.In_Valid = 1'b1;
      checks += 2;
      if (bif.In_Ready !== 1'b1) begin
         errors++; $display("FAIL c1_in_ready: got %b expected 1", bif.In_Ready);
      end
      if (key_addr !== 4'd10) begin
         errors++; $display("FAIL c1_addr0: got %0d expected 10", key_addr);
      end
      for (int i = 1; i <= 11; i++) begin
         logic [3:0] ea;
         step();
         bif.In_Valid = 1'b0;
         ea = (i <= 10) ? 4'(10 - i) : 4'd10;
         checks += 3;
         if (key_addr !== ea) begin
            errors++; $display("FAIL c1_addr[%0d]: got %0d expected %0d", i, key_addr, ea);
         end
         if (bif.In_Ready !== 1'b0) begin
            errors++; $display("FAIL c1_busy[%0d]: in_ready %b expected 0", i, bif.In_Ready);
         end
         if (bif.Out_Valid !== (i == 11)) begin
            errors++;
            $display("FAIL c1_latency[%0d]: out_valid %b expected %b", i, bif.Out_Valid, i == 11);
         end
      end
      drain(2);
   endtask

   task automatic test_backpressure();
      logic [127:0] pa, ca, pb, cb;
      mk(pa, ca);
      mk(pb, cb);
      bif.Out_Ready = 1'b0;
      bif.Data_In = ca;
      cur_pt = pa;
      bif.In_Valid = 1'b1;
      step();
      bif.In_Valid = 1'b0;
      for (int i = 0; i < 20 && !bif.Out_Valid; i++) step();
      checks++;
      if (!bif.Out_Valid) begin
         errors++; $display("FAIL bp_timeout: out_valid 0 expected 1");
      end
      bif.Data_In = cb;
      cur_pt = pb;
      bif.In_Valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bif.Data_Out !== pa || bif.Out_Valid !== 1'b1 || bif.In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: data %h ov %b ir %b expected %h 1 0",
                     k, bif.Data_Out, bif.Out_Valid, bif.In_Ready, pa);
         end
         step();
      end
      bif.Out_Ready = 1'b1;
      step();
      checks++;
      if (bif.In_Ready !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_release: in_ready %b pending %0d expected 1 0",
                  bif.In_Ready, exp_q.size());
      end
      step();
      bif.In_Valid = 1'b0;
      checks++;
      if (key_addr !== 4'd9) begin
         errors++; $display("FAIL bp_next_accept: key_addr %0d expected 9", key_addr);
      end
      drain(20);
   endtask

   task automatic test_back_to_back();
      logic [127:0] pa, ca, pb, cb;
      int a0;
      mk(pa, ca);
      mk(pb, cb);
      a0 = acc_cnt;
      bif.Out_Ready = 1'b1;
      bif.Data_In = ca;
      cur_pt = pa;
      bif.In_Valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (acc_cnt == a0 + 1) begin
            bif.Data_In = cb;
            cur_pt = pb;
         end
         if (acc_cnt >= a0 + 2) break;
      end
      bif.In_Valid = 1'b0;
      checks += 2;
      if (acc_cnt != a0 + 2) begin
         errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - a0);
      end
      if (acc_gap != 12) begin
         errors++; $display("FAIL b2b_gap: got %0d cycles expected 12", acc_gap);
      end
      drain(30);
   endtask

   task automatic test_reset_mid();
      logic [127:0] pd, cd;
      mk(pd, cd);
      bif.Out_Ready = 1'b1;
      bif.Data_In = cd;
      cur_pt = pd;
      bif.In_Valid = 1'b1;
      step();
      bif.In_Valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (key_addr !== 4'd5) begin
         errors++; $display("FAIL rm_round5: key_addr %0d expected 5", key_addr);
      end
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      checks++;
      if (bif.Out_Valid !== 1'b0 || bif.In_Ready !== 1'b0 || key_addr !== 4'd10) begin
         errors++;
         $display("FAIL rm_after_reset: ov %b ir %b addr %0d expected 0 0 10",
                  bif.Out_Valid, bif.In_Ready, key_addr);
      end
      step();
      checks++;
      if (bif.In_Ready !== 1'b1) begin
         errors++; $display("FAIL rm_idle: in_ready %b expected 1", bif.In_Ready);
      end
      bif.Data_In = C1_CT;
      cur_pt = C1_PT;
      bif.In_Valid = 1'b1;
      step();
      bif.In_Valid = 1'b0;
      drain(20);
   endtask

`ifdef AES_INV_ABORT_EN
   task automatic test_abort();
      logic [127:0] pa, ca, pb, cb;
      mk(pa, ca);
      mk(pb, cb);
      bif.Out_Ready = 1'b1;
      bif.Data_In = ca;
      cur_pt = pa;
      bif.In_Valid = 1'b1;
      step();
      bif.In_Valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (key_addr !== 4'd3) begin
         errors++; $display("FAIL ab_round3: key_addr %0d expected 3", key_addr);
      end
      abort_s = 1'b1;
      exp_q.delete();
      step();
      abort_s = 1'b0;
      checks++;
      if (bif.In_Ready !== 1'b1 || bif.Out_Valid !== 1'b0 || key_addr !== 4'd10) begin
         errors++;
         $display("FAIL ab_idle: ir %b ov %b addr %0d expected 1 0 10",
                  bif.In_Ready, bif.Out_Valid, key_addr);
      end
      bif.Out_Ready = 1'b0;
      bif.Data_In = cb;
      cur_pt = pb;
      bif.In_Valid = 1'b1;
      step();
      bif.In_Valid = 1'b0;
      for (int i = 0; i < 20 && !bif.Out_Valid; i++) step();
      checks++;
      if (!bif.Out_Valid) begin
         errors++; $display("FAIL ab_timeout: out_valid 0 expected 1");
      end
      abort_s = 1'b1;
      bif.Out_Ready = 1'b1;
      exp_q.delete();
      step();
      abort_s = 1'b0;
      checks++;
      if (bif.Out_Valid !== 1'b0 || bif.In_Ready !== 1'b1) begin
         errors++;
         $display("FAIL ab_done: ov %b ir %b expected 0 1", bif.Out_Valid, bif.In_Ready);
      end
      for (int i = 0; i < 3; i++) step();
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bif.In_Valid = 1'b0;
      bif.Data_In = '0;
      bif.Out_Ready = 1'b0;
      cur_pt = '0;
      init_sbox();
      expand(C1_KEY);
      test_reset();
      test_c1();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef AES_INV_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 decryption controller. It accepts one 128-bit ciphertext block per transaction and runs the ten inverse rounds over a single registered state, one round per cycle. It fetches round keys from an external synchronous key memory and returns the plaintext on a valid/ready output channel. It sits between the block I/O layer and the combinational inverse-round datapath (inverse ShiftRows, inverse SubBytes, AddRoundKey, inverse MixColumns).

## Interface
Parameters:
- NR, 10: number of rounds. Only 10 (AES-128) is supported.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Data_In  input  [0:127]  ciphertext block. Byte k is Data_In[8k:8k+7]; bytes are placed in the state column-major (byte 0 = row0/col0, byte 1 = row1/col0, …).
- In_Valid  input  1  Data_In is valid.
- In_Ready  output  1  block can be accepted this cycle.
- Key_Addr  output  4  registered round-key index (0..10) presented to the key memory.
- Key_In  input  [0:127]  round key. Equals mem[Key_Addr of the previous cycle] (one-cycle read latency).
- Data_Out  output  [0:127]  plaintext. Same byte order as Data_In.
- Out_Valid  output  1  Data_Out is valid.
- Out_Ready  input  1  downstream accepts Data_Out.
- Abort  input  1  present only with AES_INV_ABORT_EN.

## Operation
States:
- PRIME: entered on reset; lasts one cycle so Key_In reflects Key_Addr=10; then goes to IDLE.
- IDLE: In_Ready=1.
- ROUND: covers rounds 9..1.
- FINAL: round 0.
- DONE: Out_Valid=1.

Behaviour by state:
- **Accept** (IDLE and In_Valid): state <= Data_In XOR Key_In (rk10); round <= 9; Key_Addr <= 9; go to ROUND.
- **ROUND, round r**: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR Key_In); Key_Addr <= r-1; round <= r-1. When r=1, go to FINAL.
- **FINAL**: state <= InvSubBytes(InvShiftRows(state)) XOR Key_In (rk0); Key_Addr <= 10; go to DONE.
- **DONE**: Data_Out = state, held stable while Out_Valid=1 and Out_Ready=0. On Out_Ready, go to IDLE. Key_Addr is already 10, so IDLE needs no priming.

General rules:
- In_Valid is ignored outside IDLE; In_Ready=0 in PRIME, ROUND, FINAL and DONE.
- Round counter is 4 bits and never wraps. Only values 9..0 occur in ROUND and FINAL.
- **Reset values**: state PRIME, In_Ready=0, Out_Valid=0, Data_Out=0, Key_Addr=10, round=0.
- **Reset mid-operation**: the in-flight block is discarded and no output is produced. The controller restarts in PRIME.
- The byte-permutation for inverse ShiftRows is applied on the column-major state: row1 rotates right by 1 column, row2 by 2, row3 by 3.

## Timing
- Accept at edge T. ROUND edges are T+1..T+9, FINAL is T+10, and Out_Valid=1 from T+11. Accept-to-output latency is 11 cycles.
- Earliest next accept: the cycle after DONE and Out_Ready. Sustained throughput is 1 block per 12 cycles with Out_Ready held high.
- First accept after reset deasserts: no earlier than 2 cycles (PRIME, then IDLE).
- Key_Addr changes only on clock edges. The key memory must not be rewritten while the controller is outside IDLE.

## Configuration
- AES_INV_ABORT_EN defined:
  - Adds the Abort input.
  - Abort=1 in ROUND, FINAL or DONE goes to IDLE on the next edge, drops Out_Valid and sets Key_Addr <= 10.
  - Abort in IDLE or PRIME has no effect.
  - Abort beats Out_Ready when both are asserted in DONE; the block is dropped.
  - Abort and reset together: reset wins.
- Not defined: no Abort port. A started block always completes.

## Structure
- Shared package aes_inv_pkg holds:
  - NR=10 and KEY_IDX_W=4.
  - The state encoding constants (PRIME, IDLE, ROUND, FINAL, DONE).
  - The byte-index helper for column-major placement.
- One sub-module, aes_inv_round: combinational; inputs state, round key and a last flag; it chains the existing inverse ShiftRows, SubBytes and MixColumns blocks and bypasses MixColumns when last=1.
- The controller holds only the FSM, the counter, the state register and the handshake.

## Test plan
- **FIPS-197 C.1**: key memory holds the expansion of 000102…0f; Data_In=69c4e0d86a7b0430d8cdb78070b4c55a -> Data_Out=00112233445566778899aabbccddeeff with Out_Valid exactly 11 cycles after accept.
- **Key address sequence**: for the C.1 block, Key_Addr reads 10,9,8,…,1,0,10 on consecutive cycles from the accept edge; In_Ready=0 throughout.
- **Output backpressure**: Out_Ready=0 for 5 cycles in DONE -> Data_Out is stable and In_Ready=0; at Out_Ready=1 there is one transfer, and the next block is accepted the following cycle.
- **Back-to-back blocks**: two blocks with In_Valid held high and Out_Ready=1 -> both decrypt correctly and the accepts are 12 cycles apart.
- **Reset mid-round**: reset asserted at round 5 -> next cycle shows Out_Valid=0, In_Ready=0 and Key_Addr=10; In_Ready=1 two cycles after reset deasserts; a fresh C.1 block decrypts correctly.
- **Abort** (AES_INV_ABORT_EN): Abort at round 3 -> IDLE next cycle with no Out_Valid; Abort together with Out_Ready in DONE -> no transfer.
